// File: rtl/cordic_pkg.sv
// Shared types and defaults for the CORDIC phase generator.
// Holds data/angle defaults, FSM states and the fold-stage bundle.
package cordic_pkg;

  localparam int DATA_W   = 16;
  localparam int ANGLE_90 = 23170;
  localparam int X_INIT   = 19898;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } phase_gen_state_t;

  typedef struct packed {
    logic        valid;
    logic        last;
    logic        fold;
    logic [16:0] th;
  } fold_s1_t;

endpackage

// File: rtl/cordic_phase_fold.sv
// Two-stage fold (to +/-90 deg) and scale (to CORDIC angle units) pipeline.
// Ports: clk, reset_n, adv (stall when 0), in_valid/in_last/in_phase -> angle/fold/last/valid.
module cordic_phase_fold #(
  parameter int DW  = 16,
  parameter int A90 = 23170
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 adv,
  input  logic                 in_valid,
  input  logic                 in_last,
  input  logic [15:0]          in_phase,
  output logic signed [DW-1:0] angle,
  output logic                 fold,
  output logic                 last,
  output logic                 valid
);
  import cordic_pkg::*;

  localparam logic signed [31:0] A90W = 32'(A90);

  fold_s1_t           s1_d;
  fold_s1_t           s1_q;
  logic signed [16:0] th;
  logic signed [16:0] th_q;
  logic signed [31:0] prod;

  always_comb begin
    th         = {in_phase[15], in_phase};
    s1_d.valid = in_valid;
    s1_d.last  = in_last;
    s1_d.fold  = 1'b0;
    s1_d.th    = th;
    if (th > 17'sh04000) begin
      s1_d.th   = 17'sh08000 - th;
      s1_d.fold = 1'b1;
    end else if (th < -17'sh04000) begin
      s1_d.th   = -17'sh08000 - th;
      s1_d.fold = 1'b1;
    end
  end

  assign th_q = s1_q.th;
  assign prod = $signed({{15{th_q[16]}}, th_q}) * A90W;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q  <= '0;
      angle <= '0;
      fold  <= 1'b0;
      last  <= 1'b0;
      valid <= 1'b0;
    end else if (adv) begin
      s1_q  <= s1_d;
      valid <= s1_q.valid;
      last  <= s1_q.valid & s1_q.last;
      fold  <= s1_q.valid & s1_q.fold;
      angle <= s1_q.valid ? DW'(prod >>> 14) : '0;
    end
  end

endmodule

// File: rtl/cordic_phase_gen.sv
// NCO burst generator feeding the cordic rotator with folded, scaled angles.
// Ports: start/stop/ftw/phase_init/n_samples/out_ready in; angle/x/y/valid/fold/last/busy/done out.
module cordic_phase_gen #(
  parameter int PHASE_W  = 32,
  parameter int DATA_W   = cordic_pkg::DATA_W,
  parameter int ANGLE_90 = cordic_pkg::ANGLE_90,
  parameter int X_INIT   = cordic_pkg::X_INIT,
  parameter int CNT_W    = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     stop,
  input  logic [PHASE_W-1:0]       ftw,
  input  logic [PHASE_W-1:0]       phase_init,
  input  logic [CNT_W-1:0]         n_samples,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] angle_o,
  output logic signed [DATA_W-1:0] x_o,
  output logic signed [DATA_W-1:0] y_o,
  output logic                     valid_o,
  output logic                     fold_o,
  output logic                     last_o,
  output logic                     busy,
  output logic                     done
);
  import cordic_pkg::*;

  phase_gen_state_t   state_q;
  phase_gen_state_t   state_d;
  logic [PHASE_W-1:0] acc_q;
  logic [PHASE_W-1:0] ftw_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               adv;
  logic               issue;
  logic               issue_last;
  logic               last_hs;
  logic               done_q;

  assign adv        = out_ready | ~valid_o;
  assign issue      = (state_q == RUN) & adv;
  // cnt stays 0 in continuous mode, so only stop can end it
  assign issue_last = stop | (cnt_q == CNT_W'(1));
  assign last_hs    = valid_o & out_ready & last_o;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (issue && issue_last) state_d = DRAIN;
      DRAIN:   if (last_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ftw_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == DRAIN) & last_hs;
      if (state_q == IDLE && start) begin
        acc_q <= phase_init;
        ftw_q <= ftw;
        cnt_q <= n_samples;
      end else if (issue) begin
        acc_q <= acc_q + ftw_q;
        if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  cordic_phase_fold #(
    .DW  (DATA_W),
    .A90 (ANGLE_90)
  ) u_fold (
    .clk      (clk),
    .reset_n  (reset_n),
    .adv      (adv),
    .in_valid (issue),
    .in_last  (issue_last),
    .in_phase (acc_q[PHASE_W-1 -: 16]),
    .angle    (angle_o),
    .fold     (fold_o),
    .last     (last_o),
    .valid    (valid_o)
  );

  assign x_o  = valid_o ? DATA_W'(X_INIT) : '0;
  assign y_o  = '0;
  assign busy = (state_q != IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_cordic_phase_gen.sv
// Scoreboard bench for cordic_phase_gen: directed bursts, stalls, stop, reset.
// Expected samples are queued at stimulus time and popped by a negedge monitor.
module tb_cordic_phase_gen;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               start = 1'b0;
  logic               stop = 1'b0;
  logic [31:0]        ftw = '0;
  logic [31:0]        phase_init = '0;
  logic [15:0]        n_samples = '0;
  logic               out_ready = 1'b1;
  logic signed [15:0] angle_o;
  logic signed [15:0] x_o;
  logic signed [15:0] y_o;
  logic               valid_o;
  logic               fold_o;
  logic               last_o;
  logic               busy;
  logic               done;

  cordic_phase_gen dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .stop       (stop),
    .ftw        (ftw),
    .phase_init (phase_init),
    .n_samples  (n_samples),
    .out_ready  (out_ready),
    .angle_o    (angle_o),
    .x_o        (x_o),
    .y_o        (y_o),
    .valid_o    (valid_o),
    .fold_o     (fold_o),
    .last_o     (last_o),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] angle;
    logic        fold;
    logic        last;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   hs_cnt = 0;
  int   done_cnt = 0;
  bit   exp_done = 1'b0;
  logic p_valid = 1'b0;
  logic p_ready = 1'b0;
  logic p_fold = 1'b0;
  logic p_last = 1'b0;
  logic [15:0] p_angle = '0;

  int a45[8] = '{0, 11585, 23170, 11585, 0, -11585, -23170, -11585};
  bit f45[8] = '{0, 0, 0, 1, 1, 1, 0, 0};

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push(int a, bit f, bit l);
    exp_t e;
    e.angle = 16'(a);
    e.fold  = f;
    e.last  = l;
    q.push_back(e);
  endtask

  task automatic push45(int n);
    for (int i = 0; i < n; i++) push(a45[i], f45[i], i == n - 1);
  endtask

  task automatic go(logic [31:0] f, logic [31:0] p, logic [15:0] n, bit s);
    ftw = f;
    phase_init = p;
    n_samples = n;
    start = 1'b1;
    stop = s;
    @(posedge clk); #1;
    start = 1'b0;
    stop = 1'b0;
    ftw = 32'hDEAD_BEEF;
    phase_init = 32'h1357_9BDF;
    n_samples = 16'd3;
  endtask

  task automatic wait_hs(string name, int n);
    int h0 = hs_cnt;
    int k = 0;
    while (hs_cnt < h0 + n && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    chk(name, 32'(hs_cnt - h0), 32'(n));
  endtask

  task automatic finish_burst(string name);
    int d0 = done_cnt;
    int k = 0;
    while (done_cnt == d0 && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk({name, "_done_count"}, 32'(done_cnt - d0), 32'd1);
    chk({name, "_queue_left"}, 32'(q.size()), 32'd0);
    chk({name, "_busy_idle"}, {31'd0, busy}, 32'd0);
    q.delete();
  endtask

  task automatic chk_zero(string name);
    chk({name, "_angle"}, {16'd0, angle_o}, 32'd0);
    chk({name, "_x"}, {16'd0, x_o}, 32'd0);
    chk({name, "_y"}, {16'd0, y_o}, 32'd0);
    chk({name, "_valid"}, {31'd0, valid_o}, 32'd0);
    chk({name, "_fold"}, {31'd0, fold_o}, 32'd0);
    chk({name, "_last"}, {31'd0, last_o}, 32'd0);
    chk({name, "_busy"}, {31'd0, busy}, 32'd0);
    chk({name, "_done"}, {31'd0, done}, 32'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      p_valid = 1'b0;
      exp_done = 1'b0;
    end else begin
      if (exp_done) begin
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("busy_at_done", {31'd0, busy}, 32'd0);
        exp_done = 1'b0;
      end else if (done) begin
        chk("spurious_done", {31'd0, done}, 32'd0);
      end
      if (done) done_cnt++;
      if (p_valid && !p_ready) begin
        chk("hold_valid", {31'd0, valid_o}, 32'd1);
        chk("hold_angle", {16'd0, angle_o}, {16'd0, p_angle});
        chk("hold_fold", {31'd0, fold_o}, {31'd0, p_fold});
        chk("hold_last", {31'd0, last_o}, {31'd0, p_last});
      end
      if (valid_o && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_sample", {31'd0, valid_o}, 32'd0);
        end else begin
          e = q.pop_front();
          chk("angle", {16'd0, angle_o}, {16'd0, e.angle});
          chk("fold", {31'd0, fold_o}, {31'd0, e.fold});
          chk("last", {31'd0, last_o}, {31'd0, e.last});
          chk("x_const", {16'd0, x_o}, 32'd19898);
          chk("y_zero", {16'd0, y_o}, 32'd0);
          chk("busy_sample", {31'd0, busy}, 32'd1);
        end
        if (last_o) exp_done = 1'b1;
        hs_cnt++;
      end
      p_valid = valid_o;
      p_ready = out_ready;
      p_angle = angle_o;
      p_fold  = fold_o;
      p_last  = last_o;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    reset_n = 1'b1;
    @(posedge clk); #1;

    // 45-degree steps, with first-sample latency check
    push45(8);
    go(32'h2000_0000, 32'h0, 16'd8, 1'b0);
    chk("lat_e0_busy", {31'd0, busy}, 32'd1);
    chk("lat_e0_valid", {31'd0, valid_o}, 32'd0);
    @(posedge clk); #1;
    chk("lat_e1_valid", {31'd0, valid_o}, 32'd0);
    @(posedge clk); #1;
    chk("lat_e2_valid", {31'd0, valid_o}, 32'd1);
    finish_burst("basic");

    // backpressure after the 3rd sample
    push45(8);
    go(32'h2000_0000, 32'h0, 16'd8, 1'b0);
    wait_hs("stall_reach", 3);
    out_ready = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    finish_burst("stall");

    // continuous mode ended by stop on the 5th issue
    push(0, 0, 0);
    push(5792, 0, 0);
    push(11585, 0, 0);
    push(17377, 0, 0);
    push(23170, 0, 1);
    go(32'h1000_0000, 32'h0, 16'd0, 1'b0);
    repeat (4) begin
      @(posedge clk); #1;
    end
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    finish_burst("cont_stop");

    // stop together with the count-1 sample
    push45(3);
    go(32'h2000_0000, 32'h0, 16'd3, 1'b0);
    repeat (2) begin
      @(posedge clk); #1;
    end
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    finish_burst("stop_last");

    // asynchronous reset mid-burst, then a fresh run
    push45(8);
    go(32'h2000_0000, 32'h0, 16'd8, 1'b0);
    wait_hs("rst_reach", 3);
    reset_n = 1'b0;
    #1;
    chk_zero("mid_reset");
    q.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    push45(8);
    go(32'h2000_0000, 32'h0, 16'd8, 1'b0);
    finish_burst("after_reset");

    // start and new settings during RUN are ignored
    push45(8);
    go(32'h2000_0000, 32'h0, 16'd8, 1'b0);
    repeat (2) begin
      @(posedge clk); #1;
    end
    start = 1'b1;
    ftw = 32'h1234_5678;
    phase_init = 32'h1111_1111;
    n_samples = 16'd5;
    @(posedge clk); #1;
    start = 1'b0;
    finish_burst("restart_ignored");

    // -90 deg boundary, start with stop high
    push(-23170, 0, 0);
    push(-23170, 0, 1);
    go(32'h0, 32'hC000_0000, 16'd2, 1'b1);
    finish_burst("minus90");

    // -180 deg folds to 0
    push(0, 1, 1);
    go(32'h0, 32'h8000_0000, 16'd1, 1'b0);
    finish_burst("minus180");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
